// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack engine: geometry, frame layout, direction and state encodings.
package stack_unit_pkg;

  localparam logic [7:0] DEF_STACK_BASE  = 8'hFF;
  localparam int         DEF_STACK_DEPTH = 32;

  localparam int FRAME_BYTES = 2;
  localparam int BEAT_PC     = 0;
  localparam int BEAT_FLAGS  = 1;

  // Direction encoding shared with the controller
  localparam logic PUSH = 1'b0;
  localparam logic POP  = 1'b1;

  // Flags byte layout: {2'b00, IE, IF, Z, C, N, V}
  localparam int FLAGS_W = 6;
  localparam int FLAG_IE = 5;
  localparam int FLAG_IF = 4;
  localparam int FLAG_Z  = 3;
  localparam int FLAG_C  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_V  = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT1 = 1'b1
  } state_t;

endpackage

// File: rtl/stack_unit_ptr.sv
// Stack occupancy counter and beat address generation.
// STACK_UNIT_GUARD_EN lets the count reach STACK_DEPTH; otherwise it wraps modulo STACK_DEPTH.
module stack_unit_ptr
  import stack_unit_pkg::*;
#(
  parameter logic [7:0] STACK_BASE  = DEF_STACK_BASE,
  parameter int         STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step_en,
  input  logic                           step_pop,
  output logic [$clog2(STACK_DEPTH):0]   cnt,
  output logic [7:0]                     addr,
  output logic                           push_room,
  output logic                           pop_avail
);

  localparam int              CW   = $clog2(STACK_DEPTH) + 1;
  localparam logic [CW-1:0]   MASK = CW'(STACK_DEPTH - 1);

  logic [CW-1:0] pop_off;

  // A pop reads the top byte; masking makes an empty pop address the wrapped top
  assign pop_off   = (cnt - CW'(1)) & MASK;
  assign addr      = step_pop ? (STACK_BASE - 8'(pop_off)) : (STACK_BASE - 8'(cnt));
  assign push_room = (cnt <= CW'(STACK_DEPTH - 2));
  assign pop_avail = (cnt >= CW'(2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (step_en) begin
`ifdef STACK_UNIT_GUARD_EN
      cnt <= step_pop ? (cnt - CW'(1)) : (cnt + CW'(1));
`else
      cnt <= (step_pop ? (cnt - CW'(1)) : (cnt + CW'(1))) & MASK;
`endif
    end
  end

endmodule

// File: rtl/stack_unit.sv
// Stack engine moving {PC, flags} frames over the data-memory bus in two beats.
// Optional overflow/underflow refusal is enabled by defining STACK_UNIT_GUARD_EN.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter logic [7:0] STACK_BASE  = DEF_STACK_BASE,
  parameter int         STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stack_op_ongoing,
  input  logic                           push_or_pop,
  output logic                           stack_op_end,
  input  logic                           bus_grant,
  output logic                           stack_bus_en,
  output logic [7:0]                     stack_addr,
  output logic [7:0]                     stack_wr_data,
  input  logic [7:0]                     stack_rd_data,
  input  logic [7:0]                     pc_din,
  input  logic [FLAGS_W-1:0]             flags_din,
  output logic [7:0]                     pc_dout,
  output logic [FLAGS_W-1:0]             flags_dout,
  output logic [$clog2(STACK_DEPTH):0]   stack_cnt,
  output logic                           stack_err
);

  state_t state;
  logic   dir;
  logic   cur_dir;
  logic   refuse;
  logic   beat_valid;
  logic   granted;
  logic   push_room;
  logic   pop_avail;
  logic [7:0] ptr_addr;
  logic   unused_rd_hi;

  assign unused_rd_hi = ^stack_rd_data[7:6];

  // Beat 0 follows the live direction; beat 1 uses the direction latched at frame start
  assign cur_dir = (state == ST_IDLE) ? push_or_pop : dir;

`ifdef STACK_UNIT_GUARD_EN
  assign refuse = rst && stack_op_ongoing && (state == ST_IDLE) &&
                  (((cur_dir == PUSH) && !push_room) || ((cur_dir == POP) && !pop_avail));
`else
  logic unused_guard;
  assign unused_guard = push_room ^ pop_avail;
  assign refuse       = 1'b0;
`endif

  assign beat_valid   = rst && stack_op_ongoing && !refuse;
  assign granted      = beat_valid && bus_grant;
  assign stack_bus_en = beat_valid;
  assign stack_op_end = ((state == ST_BEAT1) && granted) || refuse;
  assign stack_addr   = beat_valid ? ptr_addr : 8'h00;

  always_comb begin
    stack_wr_data = 8'h00;
    if (beat_valid && (cur_dir == PUSH)) begin
      stack_wr_data = (state == ST_IDLE) ? pc_din : {2'b00, flags_din};
    end
  end

  stack_unit_ptr #(
    .STACK_BASE  (STACK_BASE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .step_en   (granted),
    .step_pop  (cur_dir == POP),
    .cnt       (stack_cnt),
    .addr      (ptr_addr),
    .push_room (push_room),
    .pop_avail (pop_avail)
  );

  // Frame sequencer; popped bytes land in the output registers as each pop beat is granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dir        <= PUSH;
      pc_dout    <= '0;
      flags_dout <= '0;
`ifdef STACK_UNIT_GUARD_EN
      stack_err  <= 1'b0;
`endif
    end else begin
`ifdef STACK_UNIT_GUARD_EN
      if (refuse) stack_err <= 1'b1;
`endif
      case (state)
        ST_IDLE: begin
          if (granted) begin
            dir   <= cur_dir;
            state <= ST_BEAT1;
            if (cur_dir == POP) flags_dout <= stack_rd_data[FLAGS_W-1:0];
          end
        end
        ST_BEAT1: begin
          if (!stack_op_ongoing) begin
            state <= ST_IDLE;
          end else if (granted) begin
            state <= ST_IDLE;
            if (dir == POP) pc_dout <= stack_rd_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef STACK_UNIT_GUARD_EN
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit; guard-dependent scenarios follow STACK_UNIT_GUARD_EN.
module tb_stack_unit;
  import stack_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stack_op_ongoing = 1'b0;
  logic       push_or_pop = PUSH;
  logic       stack_op_end;
  logic       bus_grant = 1'b0;
  logic       stack_bus_en;
  logic [7:0] stack_addr;
  logic [7:0] stack_wr_data;
  logic [7:0] stack_rd_data = 8'h00;
  logic [7:0] pc_din = 8'h00;
  logic [5:0] flags_din = 6'h00;
  logic [7:0] pc_dout;
  logic [5:0] flags_dout;
  logic [5:0] stack_cnt;
  logic       stack_err;

  int tests_run    = 0;
  int tests_failed = 0;

  stack_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stack_op_ongoing (stack_op_ongoing),
    .push_or_pop      (push_or_pop),
    .stack_op_end     (stack_op_end),
    .bus_grant        (bus_grant),
    .stack_bus_en     (stack_bus_en),
    .stack_addr       (stack_addr),
    .stack_wr_data    (stack_wr_data),
    .stack_rd_data    (stack_rd_data),
    .pc_din           (pc_din),
    .flags_din        (flags_din),
    .pc_dout          (pc_dout),
    .flags_dout       (flags_dout),
    .stack_cnt        (stack_cnt),
    .stack_err        (stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    tests_run++; if (stack_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt got %0d want 0", stack_cnt); end
    tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", stack_err); end
    tests_run++; if (pc_dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pc got %h want 00", pc_dout); end
    tests_run++; if (flags_dout !== 6'h00) begin tests_failed++; $display("[TB] FAIL reset_flags got %h want 00", flags_dout); end
    tests_run++; if (stack_bus_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bus_en got %b want 0", stack_bus_en); end
    tests_run++; if (stack_addr !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_addr got %h want 00", stack_addr); end
  endtask

  task automatic test_push();
    push_or_pop = PUSH; pc_din = 8'h3C; flags_din = 6'h25; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    #1;
    tests_run++; if (stack_bus_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL push_b0_en got %b want 1", stack_bus_en); end
    tests_run++; if (stack_addr !== 8'hFF) begin tests_failed++; $display("[TB] FAIL push_b0_addr got %h want FF", stack_addr); end
    tests_run++; if (stack_wr_data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL push_b0_data got %h want 3C", stack_wr_data); end
    tests_run++; if (stack_op_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL push_b0_end got %b want 0", stack_op_end); end
    tick();
    tests_run++; if (stack_addr !== 8'hFE) begin tests_failed++; $display("[TB] FAIL push_b1_addr got %h want FE", stack_addr); end
    tests_run++; if (stack_wr_data !== 8'h25) begin tests_failed++; $display("[TB] FAIL push_b1_data got %h want 25", stack_wr_data); end
    tests_run++; if (stack_op_end !== 1'b1) begin tests_failed++; $display("[TB] FAIL push_b1_end got %b want 1", stack_op_end); end
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_cnt !== 6'd2) begin tests_failed++; $display("[TB] FAIL push_cnt got %0d want 2", stack_cnt); end
    tests_run++; if (stack_bus_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL push_idle_en got %b want 0", stack_bus_en); end
  endtask

  task automatic test_pop();
    push_or_pop = POP; stack_rd_data = 8'h25; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    #1;
    tests_run++; if (stack_addr !== 8'hFE) begin tests_failed++; $display("[TB] FAIL pop_b0_addr got %h want FE", stack_addr); end
    tests_run++; if (stack_wr_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL pop_b0_wdata got %h want 00", stack_wr_data); end
    tick();
    push_or_pop = PUSH;
    stack_rd_data = 8'h3C;
    #1;
    tests_run++; if (stack_addr !== 8'hFF) begin tests_failed++; $display("[TB] FAIL pop_b1_addr got %h want FF", stack_addr); end
    tests_run++; if (stack_op_end !== 1'b1) begin tests_failed++; $display("[TB] FAIL pop_b1_end got %b want 1", stack_op_end); end
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0; stack_rd_data = 8'h00;
    #1;
    tests_run++; if (pc_dout !== 8'h3C) begin tests_failed++; $display("[TB] FAIL pop_pc got %h want 3C", pc_dout); end
    tests_run++; if (flags_dout !== 6'h25) begin tests_failed++; $display("[TB] FAIL pop_flags got %h want 25", flags_dout); end
    tests_run++; if (stack_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL pop_cnt got %0d want 0", stack_cnt); end
  endtask

  task automatic test_wait_states();
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_end;
    push_or_pop = PUSH; pc_din = 8'hA5; flags_din = 6'h3F; stack_op_ongoing = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_grant = (i == 3) || (i == 7);
      exp_addr  = (i < 4) ? 8'hFF : 8'hFE;
      exp_data  = (i < 4) ? 8'hA5 : 8'h3F;
      exp_end   = (i == 7);
      #1;
      tests_run++; if (stack_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL wait_addr cycle %0d got %h want %h", i, stack_addr, exp_addr); end
      tests_run++; if (stack_wr_data !== exp_data) begin tests_failed++; $display("[TB] FAIL wait_data cycle %0d got %h want %h", i, stack_wr_data, exp_data); end
      tests_run++; if (stack_op_end !== exp_end) begin tests_failed++; $display("[TB] FAIL wait_end cycle %0d got %b want %b", i, stack_op_end, exp_end); end
      tick();
    end
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_cnt !== 6'd2) begin tests_failed++; $display("[TB] FAIL wait_cnt got %0d want 2", stack_cnt); end
  endtask

  task automatic test_early_deassert();
    push_or_pop = PUSH; pc_din = 8'h11; flags_din = 6'h01; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    #1;
    tests_run++; if (stack_addr !== 8'hFD) begin tests_failed++; $display("[TB] FAIL early_addr got %h want FD", stack_addr); end
    tick();
    stack_op_ongoing = 1'b0;
    #1;
    tests_run++; if (stack_op_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_end got %b want 0", stack_op_end); end
    tests_run++; if (stack_bus_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_en got %b want 0", stack_bus_en); end
    tick();
    tests_run++; if (stack_cnt !== 6'd3) begin tests_failed++; $display("[TB] FAIL early_cnt got %0d want 3", stack_cnt); end
    // A fresh frame must start at beat 0 again
    stack_op_ongoing = 1'b1; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_wr_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL early_restart_data got %h want 11", stack_wr_data); end
    stack_op_ongoing = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    push_or_pop = PUSH; pc_din = 8'h42; flags_din = 6'h02; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    #1;
    tests_run++; if (stack_addr !== 8'hFC) begin tests_failed++; $display("[TB] FAIL midrst_addr got %h want FC", stack_addr); end
    tick();
    rst = 1'b0;
    #1;
    tests_run++; if (stack_op_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_end got %b want 0", stack_op_end); end
    tick();
    rst = 1'b1; stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL midrst_cnt got %0d want 0", stack_cnt); end
  endtask

`ifdef STACK_UNIT_GUARD_EN
  task automatic test_overflow_guard();
    push_or_pop = PUSH; pc_din = 8'h77; flags_din = 6'h07; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    for (int f = 0; f < 32; f++) tick();
    #1;
    tests_run++; if (stack_cnt !== 6'd32) begin tests_failed++; $display("[TB] FAIL ovf_full_cnt got %0d want 32", stack_cnt); end
    tests_run++; if (stack_op_end !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_end got %b want 1", stack_op_end); end
    tests_run++; if (stack_bus_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_en got %b want 0", stack_bus_en); end
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_err got %b want 1", stack_err); end
    tests_run++; if (stack_cnt !== 6'd32) begin tests_failed++; $display("[TB] FAIL ovf_cnt got %0d want 32", stack_cnt); end
  endtask
`else
  task automatic test_underflow_wrap();
    push_or_pop = POP; stack_rd_data = 8'h1A; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    #1;
    tests_run++; if (stack_addr !== 8'hE0) begin tests_failed++; $display("[TB] FAIL unf_b0_addr got %h want E0", stack_addr); end
    tick();
    stack_rd_data = 8'h77;
    #1;
    tests_run++; if (stack_addr !== 8'hE1) begin tests_failed++; $display("[TB] FAIL unf_b1_addr got %h want E1", stack_addr); end
    tests_run++; if (stack_op_end !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf_end got %b want 1", stack_op_end); end
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_cnt !== 6'd30) begin tests_failed++; $display("[TB] FAIL unf_cnt got %0d want 30", stack_cnt); end
    tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL unf_err got %b want 0", stack_err); end
    tests_run++; if (flags_dout !== 6'h1A) begin tests_failed++; $display("[TB] FAIL unf_flags got %h want 1A", flags_dout); end
    tests_run++; if (pc_dout !== 8'h77) begin tests_failed++; $display("[TB] FAIL unf_pc got %h want 77", pc_dout); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_addr [4];
    logic       exp_end  [4];
    exp_addr = '{8'hE1, 8'hE0, 8'hFF, 8'hFE};
    exp_end  = '{1'b0, 1'b1, 1'b0, 1'b1};
    push_or_pop = PUSH; pc_din = 8'h5A; flags_din = 6'h15; bus_grant = 1'b1; stack_op_ongoing = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (stack_addr !== exp_addr[i]) begin tests_failed++; $display("[TB] FAIL b2b_addr cycle %0d got %h want %h", i, stack_addr, exp_addr[i]); end
      tests_run++; if (stack_op_end !== exp_end[i]) begin tests_failed++; $display("[TB] FAIL b2b_end cycle %0d got %b want %b", i, stack_op_end, exp_end[i]); end
      tick();
    end
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    #1;
    tests_run++; if (stack_cnt !== 6'd2) begin tests_failed++; $display("[TB] FAIL b2b_cnt got %0d want 2", stack_cnt); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_push();
    test_pop();
    test_wait_states();
    test_early_deassert();
    test_reset_mid_frame();
`ifdef STACK_UNIT_GUARD_EN
    test_overflow_guard();
`else
    test_underflow_wrap();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware stack engine on the MiniRISC data memory bus: the responder to the controller's `stack_op_ongoing` / `push_or_pop` / `stack_op_end` handshake. It keeps the stack occupancy and generates stack addresses. Each push or pop moves one 2-byte frame, {PC, flags}, through the data-memory bus granted by the arbiter. It sits beside `controller_fsm` in the CPU top level and serves JSR, RTS, RTI and interrupt entry.

## Interface
- `STACK_BASE`, 8'hFF: address of the first stack byte; the stack grows downward.
- `STACK_DEPTH`, 32: stack size in bytes; even, power of two, ≤128.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `stack_op_ongoing` in 1: a stack operation is requested; held until the cycle after `stack_op_end`.
- `push_or_pop` in 1: direction, PUSH or POP (from `control_defs.vh`); sampled only at frame start.
- `stack_op_end` out 1: final beat is granted this cycle (combinational).
- `bus_grant` in 1: the current beat's memory access completes this cycle.
- `stack_bus_en` out 1: a valid beat is presented; the top level ANDs the controller's `data_mem_wr` / `data_mem_rd` with this during stack operations.
- `stack_addr` out 8: beat address.
- `stack_wr_data` out 8: push data; 0 when not pushing.
- `stack_rd_data` in 8: data memory read data, valid in the granted cycle.
- `pc_din` in 8: PC to push.
- `flags_din` in 6: flags to push, {IE, IF, Z, C, N, V}.
- `pc_dout` out 8: popped PC.
- `flags_dout` out 6: popped flags.
- `stack_cnt` out clog2(STACK_DEPTH)+1: occupancy in bytes.
- `stack_err` out 1: sticky overflow/underflow flag.

## Operation
- **States:** IDLE and BEAT1. Register `dir` latches the direction of the frame in progress.
- **IDLE with `stack_op_ongoing`:** present beat 0 using the live `push_or_pop`.
  - On `bus_grant`: latch `dir`, update `stack_cnt`, go to BEAT1.
  - Without grant: stay in IDLE.
- **BEAT1:** present beat 1 using `dir`.
  - On `bus_grant`: update `stack_cnt`, assert `stack_op_end`, go to IDLE.
- **Push beat:** address = STACK_BASE − cnt; then cnt+1. Beat 0 writes `pc_din`; beat 1 writes {2'b00, `flags_din`}.
- **Pop beat:** address = STACK_BASE − (cnt−1); then cnt−1. Beat 0 reads the flags byte into `flags_dout` (bits 5:0); beat 1 reads `pc_dout`.
- **Arithmetic:** addresses are 8-bit, modulo 256.
- **Pop outputs:** `pc_dout` and `flags_dout` are registered and updated only on a granted pop beat, so the complete frame is valid from the cycle after `stack_op_end`.
- **Early deassertion:** if `stack_op_ongoing` drops in BEAT1, return to IDLE. Beats already granted keep their count change; `stack_op_end` is not asserted.
- **Reset values:** state IDLE, `stack_cnt` 0, `pc_dout` 0, `flags_dout` 0, `stack_err` 0. Combinational outputs are 0 while idle.
- **Reset mid-frame:** the frame is abandoned; no `stack_op_end`.

## Timing
- Minimum frame: 2 cycles. `stack_op_end` is high in the second cycle when both grants are immediate.
- Each cycle without grant adds one cycle to the frame. Address and data are held stable while waiting.
- `stack_bus_en`, `stack_addr` and `stack_wr_data` are combinational from state, `dir`, count and inputs. No registered delay exists between `stack_op_ongoing` and beat 0.
- On the cycle after `stack_op_end` the unit is idle and can accept a new frame immediately.

## Configuration
- **Macro `STACK_UNIT_GUARD_EN`:** overflow/underflow protection.
- **With the macro:** in IDLE, a push with cnt > STACK_DEPTH−2, or a pop with cnt < 2, is refused.
  - `stack_bus_en` stays 0 and `stack_op_end` is asserted in the same cycle.
  - `stack_err` is set and cleared only by reset.
  - Count and pop outputs are unchanged.
- **Without the macro:** `stack_err` is tied to 0. The count wraps modulo STACK_DEPTH, so stack_cnt < STACK_DEPTH always. A push at full overwrites the oldest bytes; a pop at empty reads the wrapped top.

## Structure
- Shared include `stack_defs.vh`: frame size (2), beat indices, state encodings, flags byte layout.
- PUSH/POP encodings remain in `control_defs.vh`.
- Natural sub-module: `stack_ptr`, an up/down occupancy counter with guard and wrap, and address generation.

## Test plan
- **Reset:** `rst`=0 for 1 cycle → `stack_cnt`=0, `stack_err`=0, `pc_dout`=0, `flags_dout`=0, `stack_bus_en`=0.
- **Push, immediate grants:** `pc_din`=8'h3C, `flags_din`=6'h25 → cycle 1: addr FF, data 3C; cycle 2: addr FE, data 25, `stack_op_end`=1; `stack_cnt`=2.
- **Pop following that push:** → cycle 1: addr FE; cycle 2: addr FF, `stack_op_end`=1; next cycle `pc_dout`=3C, `flags_dout`=25, `stack_cnt`=0.
- **Wait states:** `bus_grant` low 3 cycles on each beat → frame takes 8 cycles; address/data stable; `stack_op_end` only on the last grant.
- **Overflow, guard on:** 16 pushes (cnt=32), then a 17th → `stack_op_end` in cycle 1 with `stack_bus_en`=0; `stack_err`=1; `stack_cnt` stays 32.
- **Underflow, guard off:** pop at cnt=0 → addresses E0 then E1; `stack_cnt`=30; `stack_err`=0.
